// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between NUM_REQ OBI masters.
// Supports per-master lock for atomic sequences and routes each response back after MEM_LATENCY cycles.
module obi_mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                lock_i,
  input  logic [NUM_REQ-1:0]                we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t rr_ptr;
  idx_t lock_owner;
  logic lock_valid;

  idx_t gnt_idx;
  logic gnt_any;
  idx_t scan_idx;

  logic pipe_valid [MEM_LATENCY];
  idx_t pipe_id    [MEM_LATENCY];

  // Next master index in ring order; the ring length need not be a power of two.
  function automatic idx_t wrap_inc(input idx_t i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + idx_t'(1);
  endfunction

  // NOTE: every variable in a combinational block gets a default on entry,
  // otherwise any path that skips an assignment infers a latch.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = rr_ptr;
    if (lock_valid && req_i[lock_owner]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_owner;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!gnt_any && req_i[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
        scan_idx = wrap_inc(scan_idx);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  // The SRAM bus is forced to zero when idle so no stale master fields leak out.
  always_comb begin
    mem_req_o   = gnt_any;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_any) begin
      mem_we_o    = we_i[gnt_idx];
      mem_addr_o  = addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_be_o    = be_i[gnt_idx*BE_WIDTH +: BE_WIDTH];
      mem_wdata_o = wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_valid <= 1'b0;
    end else if (gnt_any) begin
      rr_ptr     <= wrap_inc(gnt_idx);
      lock_owner <= gnt_idx;
      lock_valid <= lock_i[gnt_idx];
    end else begin
      // Nobody requested, so any owner has dropped req and forfeits the lock.
      lock_valid <= 1'b0;
    end
  end

  // NOTE: the response pipe is reset, not left uninitialised like a RAM,
  // because a reset mid-operation must discard every in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_id[s]    <= '0;
      end
    end else begin
      pipe_valid[0] <= gnt_any;
      pipe_id[0]    <= gnt_idx;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_id[s]    <= pipe_id[s-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (pipe_valid[MEM_LATENCY-1]) begin
      rvalid_o[pipe_id[MEM_LATENCY-1]] = 1'b1;
      rdata_o                          = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: three instances (latency 1, 2, 3) share
// the same master stimulus; each scenario task checks its own expected values.
module tb_obi_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*BW-1:0] be;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   mem_rdata;

  logic [N-1:0]  gnt1, rv1, gnt2, rv2, gnt3, rv3;
  logic [DW-1:0] rd1, rd2, rd3;
  logic          mreq1, mwe1, mreq2, mwe2, mreq3, mwe3;
  logic [AW-1:0] maddr1, maddr2, maddr3;
  logic [BW-1:0] mbe1, mbe2, mbe3;
  logic [DW-1:0] mwd1, mwd2, mwd3;

  int total = 0;
  int bad   = 0;

  obi_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1),
    .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_be_o(mbe1),
    .mem_wdata_o(mwd1), .mem_rdata_i(mem_rdata));

  obi_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt2), .rvalid_o(rv2), .rdata_o(rd2),
    .mem_req_o(mreq2), .mem_we_o(mwe2), .mem_addr_o(maddr2), .mem_be_o(mbe2),
    .mem_wdata_o(mwd2), .mem_rdata_i(mem_rdata));

  obi_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3),
    .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_be_o(mbe3),
    .mem_wdata_o(mwd3), .mem_rdata_i(mem_rdata));

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    we   = w;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0;
    mem_rdata = 32'h5555_AAAA;
    #1;
    total++;
    if ({gnt1, rv1, mreq1, rv3} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b mem_req=%b rv3=%b, want all 0", gnt1, rv1, mreq1, rv3);
    end
    total++;
    if (rd1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 00000000", rd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    addr = {32'h0, 32'h0000_0040};
    be   = {4'h0, 4'hF};
    cycle(2'b01, 2'b00, 2'b00);
    total++;
    if ({gnt1, mreq1, mwe1} !== 4'b01_1_0 || maddr1 !== 32'h40) begin
      bad++;
      $display("FAIL read_grant: gnt=%b req=%b we=%b addr=%h want 01 1 0 00000040", gnt1, mreq1, mwe1, maddr1);
    end
    cycle(2'b00, 2'b00, 2'b00);
    mem_rdata = 32'hCAFE_F00D;
    #1;
    total++;
    if (rv1 !== 2'b01 || rd1 !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL read_resp_l1: rvalid=%b rdata=%h want 01 cafef00d", rv1, rd1);
    end
    total++;
    if (rv3 !== 2'b00 || rd3 !== 32'h0 || mreq1 !== 1'b0 || maddr1 !== 32'h0) begin
      bad++;
      $display("FAIL read_idle_l3: rv3=%b rd3=%h mem_req=%b addr=%h want 00 0 0 0", rv3, rd3, mreq1, maddr1);
    end
  endtask

  task automatic test_contention();
    logic [1:0] eg  [8];
    logic [1:0] ev1 [8];
    logic [1:0] ev3 [8];
    eg  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    ev1 = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    ev3 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_reset();
    addr = {32'h0000_0200, 32'h0000_0100};
    for (int c = 0; c < 8; c++) begin
      cycle((c < 4) ? 2'b11 : 2'b00, 2'b00, 2'b00);
      mem_rdata = 32'hA000_0000 + c;
      #1;
      total++;
      if (gnt1 !== eg[c] || gnt3 !== eg[c]) begin
        bad++;
        $display("FAIL contention_gnt c=%0d: got %b/%b want %b", c, gnt1, gnt3, eg[c]);
      end
      total++;
      if (rv1 !== ev1[c] || rv3 !== ev3[c]) begin
        bad++;
        $display("FAIL contention_rvalid c=%0d: got %b/%b want %b/%b", c, rv1, rv3, ev1[c], ev3[c]);
      end
      total++;
      if (rd1 !== ((ev1[c] != 2'b00) ? mem_rdata : 32'h0)) begin
        bad++;
        $display("FAIL contention_rdata c=%0d: got %h", c, rd1);
      end
    end
  endtask

  task automatic test_lock();
    logic [1:0] r  [5];
    logic [1:0] l  [5];
    logic [1:0] eg [5];
    r  = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    l  = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    eg = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cycle(r[c], l[c], 2'b00);
      total++;
      if (gnt1 !== eg[c]) begin
        bad++;
        $display("FAIL lock_gnt c=%0d: got %b want %b", c, gnt1, eg[c]);
      end
    end
  endtask

  task automatic test_lock_owner_idle();
    do_reset();
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b10, 2'b10, 2'b00);
    cycle(2'b01, 2'b00, 2'b00);
    total++;
    if (gnt1 !== 2'b01) begin
      bad++;
      $display("FAIL idle_owner_immediate: got %b want 01", gnt1);
    end
    // Owner takes the lock again, then everyone goes idle: lock must be gone.
    cycle(2'b10, 2'b10, 2'b00);
    cycle(2'b00, 2'b00, 2'b00);
    total++;
    if (gnt1 !== 2'b00 || mreq1 !== 1'b0) begin
      bad++;
      $display("FAIL idle_all: gnt=%b mem_req=%b want 00 0", gnt1, mreq1);
    end
    cycle(2'b11, 2'b00, 2'b00);
    total++;
    if (gnt1 !== 2'b01) begin
      bad++;
      $display("FAIL idle_lock_released: got %b want 01", gnt1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    addr  = {32'h0000_0200, 32'h0000_0100};
    be    = {4'hF, 4'h3};
    wdata = {32'hDEAD_BEEF, 32'h1122_3344};
    cycle(2'b01, 2'b00, 2'b01);
    total++;
    if (gnt3 !== 2'b01 || mwe3 !== 1'b1 || maddr3 !== 32'h100 || mbe3 !== 4'h3 || mwd3 !== 32'h1122_3344) begin
      bad++;
      $display("FAIL b2b_write: gnt=%b we=%b addr=%h be=%h wd=%h", gnt3, mwe3, maddr3, mbe3, mwd3);
    end
    cycle(2'b10, 2'b00, 2'b00);
    total++;
    if (gnt3 !== 2'b10 || mwe3 !== 1'b0 || maddr3 !== 32'h200 || mbe3 !== 4'hF) begin
      bad++;
      $display("FAIL b2b_read: gnt=%b we=%b addr=%h be=%h", gnt3, mwe3, maddr3, mbe3);
    end
    cycle(2'b00, 2'b00, 2'b00);
    total++;
    if (rv3 !== 2'b00 || rv1 !== 2'b10) begin
      bad++;
      $display("FAIL b2b_t2: rv3=%b rv1=%b want 00 10", rv3, rv1);
    end
    cycle(2'b00, 2'b00, 2'b00);
    total++;
    if (rv3 !== 2'b01) begin
      bad++;
      $display("FAIL b2b_t3: rv3=%b want 01", rv3);
    end
    cycle(2'b00, 2'b00, 2'b00);
    mem_rdata = 32'h0BAD_F00D;
    #1;
    total++;
    if (rv3 !== 2'b10 || rd3 !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL b2b_t4: rv3=%b rd3=%h want 10 0badf00d", rv3, rd3);
    end
    cycle(2'b00, 2'b00, 2'b00);
    total++;
    if (rv3 !== 2'b00 || rd3 !== 32'h0) begin
      bad++;
      $display("FAIL b2b_t5: rv3=%b rd3=%h want 00 0", rv3, rd3);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    mem_rdata = 32'h7777_7777;
    cycle(2'b01, 2'b00, 2'b00);
    total++;
    if (gnt2 !== 2'b01) begin
      bad++;
      $display("FAIL midrst_grant: got %b want 01", gnt2);
    end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if (rv2 !== 2'b00) begin
      bad++;
      $display("FAIL midrst_during: rv2=%b want 00", rv2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(2'b00, 2'b00, 2'b00);
      total++;
      if (rv2 !== 2'b00 || rd2 !== 32'h0) begin
        bad++;
        $display("FAIL midrst_after c=%0d: rv2=%b rd2=%h want 00 0", c, rv2, rd2);
      end
    end
    cycle(2'b11, 2'b00, 2'b00);
    total++;
    if (gnt2 !== 2'b01) begin
      bad++;
      $display("FAIL midrst_rrptr: got %b want 01", gnt2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0; mem_rdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_lock_owner_idle();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
